// File: rtl/snn_lif_layer_seq.sv
// snn_lif_layer_seq: one fully connected LIF layer (N_IN -> N_OUT) run for N_CYCLES timesteps per start,
// neurons updated one per clock. Optional `define SNN_REFRACTORY_EN adds a one-timestep refractory period.
module snn_lif_layer_seq #(
  parameter int N_IN          = 4,
  parameter int N_OUT         = 2,
  parameter int W_BW          = 8,
  parameter int V_BW          = 12,
  parameter int V_TH          = 64,
  parameter int LEAK_SHIFT    = 3,
  parameter int N_CYCLES      = 10,
  parameter int CYCLES_CNT_BW = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  output logic                            ready,
  output logic                            sample,
  input  logic                            sample_ready,
  input  logic [N_IN-1:0]                 in_spikes,
  output logic [N_OUT-1:0]                out_spikes,
  output logic                            out_valid,
  input  logic                            w_we,
  input  logic [$clog2(N_IN*N_OUT)-1:0]   w_addr,
  input  logic signed [W_BW-1:0]          w_data
);
  localparam int N_W    = N_IN * N_OUT;
  localparam int AW     = $clog2(N_W);
  localparam int K_BW   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int SUM_BW = W_BW + $clog2(N_IN + 1);
  localparam int EXT_BW = ((V_BW > SUM_BW) ? V_BW : SUM_BW) + 2;

  localparam logic signed [EXT_BW-1:0]  V_MAX    = EXT_BW'((2 ** (V_BW - 1)) - 1);
  localparam logic signed [EXT_BW-1:0]  V_MIN    = EXT_BW'(-(2 ** (V_BW - 1)));
  localparam logic signed [V_BW-1:0]    V_THRESH = V_BW'(V_TH);
  localparam logic [K_BW-1:0]           K_LAST   = K_BW'(N_OUT - 1);
  localparam logic [CYCLES_CNT_BW-1:0]  CNT_LAST = CYCLES_CNT_BW'(N_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT_S, SAMPLE, UPDATE} state_t;

  state_t                    state;
  logic signed [W_BW-1:0]    w_mem [N_W];
  logic signed [V_BW-1:0]    v_mem [N_OUT];
  logic [N_IN-1:0]           spk_latch;
  logic [N_OUT-1:0]          spk_vec;
  logic [K_BW-1:0]           k;
  logic [CYCLES_CNT_BW-1:0]  cyc_cnt;
`ifdef SNN_REFRACTORY_EN
  logic [N_OUT-1:0]          refr;
`endif

  logic signed [EXT_BW-1:0]  sum;
  logic signed [EXT_BW-1:0]  v_ext;
  logic signed [EXT_BW-1:0]  v_raw;
  logic signed [V_BW-1:0]    v_sat;
  logic signed [V_BW-1:0]    v_upd;
  logic                      fire;
  logic [N_OUT-1:0]          spk_next;
  logic [CYCLES_CNT_BW-1:0]  cnt_next;
  logic [AW-1:0]             w_idx;

  // Datapath for the neuron currently selected by k; extended width keeps leak+sum exact before clamping.
  always_comb begin
    sum   = '0;
    w_idx = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      w_idx = AW'(k * N_IN + i);
      if (spk_latch[i]) sum = sum + EXT_BW'(w_mem[w_idx]);
    end
    v_ext = EXT_BW'(v_mem[k]);
    v_raw = v_ext - (v_ext >>> LEAK_SHIFT) + sum;
    if (v_raw > V_MAX)      v_sat = V_BW'(V_MAX);
    else if (v_raw < V_MIN) v_sat = V_BW'(V_MIN);
    else                    v_sat = V_BW'(v_raw);
    fire  = (v_sat >= V_THRESH);
    v_upd = fire ? '0 : v_sat;
`ifdef SNN_REFRACTORY_EN
    if (refr[k]) begin
      fire  = 1'b0;
      v_upd = '0;
    end
`endif
    spk_next    = spk_vec;
    spk_next[k] = fire;
    cnt_next    = cyc_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ready      <= 1'b1;
      sample     <= 1'b0;
      out_valid  <= 1'b0;
      out_spikes <= '0;
      spk_latch  <= '0;
      spk_vec    <= '0;
      k          <= '0;
      cyc_cnt    <= '0;
      for (int unsigned j = 0; j < N_OUT; j++) v_mem[j] <= '0;
      for (int unsigned j = 0; j < N_W; j++)   w_mem[j] <= '0;
`ifdef SNN_REFRACTORY_EN
      refr       <= '0;
`endif
    end else begin
      sample    <= 1'b0;
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (w_we) w_mem[w_addr] <= w_data;
          if (start) begin
            for (int unsigned j = 0; j < N_OUT; j++) v_mem[j] <= '0;
            out_spikes <= '0;
            cyc_cnt    <= '0;
            ready      <= 1'b0;
            state      <= WAIT_S;
`ifdef SNN_REFRACTORY_EN
            refr       <= '0;
`endif
          end
        end
        WAIT_S: begin
          if (sample_ready) begin
            sample <= 1'b1;
            state  <= SAMPLE;
          end
        end
        SAMPLE: begin
          spk_latch <= in_spikes;
          k         <= '0;
          state     <= UPDATE;
        end
        UPDATE: begin
          v_mem[k]   <= v_upd;
          spk_vec[k] <= fire;
`ifdef SNN_REFRACTORY_EN
          refr[k]    <= fire;
`endif
          if (k == K_LAST) begin
            out_spikes <= spk_next;
            out_valid  <= 1'b1;
            cyc_cnt    <= cnt_next;
            if (cnt_next == CNT_LAST) begin
              ready <= 1'b1;
              state <= IDLE;
            end else begin
              state <= WAIT_S;
            end
          end else begin
            k <= k + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_snn_lif_layer_seq.sv
// Testbench for snn_lif_layer_seq: table-driven runs with a spike-train scoreboard plus reset and stall sequences.
module tb_snn_lif_layer_seq;
  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              ready;
  logic              sample;
  logic              sample_ready;
  logic [3:0]        in_spikes;
  logic [1:0]        out_spikes;
  logic              out_valid;
  logic              w_we;
  logic [2:0]        w_addr;
  logic signed [7:0] w_data;

  int n_checks   = 0;
  int n_fail     = 0;
  int sample_cnt = 0;
  logic [1:0] exp_q [$];

  typedef struct {
    string       name;
    logic [63:0] w;       // weight a = k*4+i in bits [8a +: 8]
    logic [3:0]  in_spk;
    logic [19:0] exp_n;   // timestep t spikes in bits [2t +: 2]
    logic [19:0] exp_r;   // same, with refractory period
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  snn_lif_layer_seq #(
    .N_IN(4), .N_OUT(2), .W_BW(8), .V_BW(12), .V_TH(64),
    .LEAK_SHIFT(3), .N_CYCLES(10), .CYCLES_CNT_BW(5)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready), .sample(sample),
    .sample_ready(sample_ready), .in_spikes(in_spikes), .out_spikes(out_spikes),
    .out_valid(out_valid), .w_we(w_we), .w_addr(w_addr), .w_data(w_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (sample) sample_cnt++;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL out_valid_extra: got out_spikes %0h, want no pulse", out_spikes);
      end else begin
        check("out_spikes", {30'd0, out_spikes}, {30'd0, exp_q.pop_front()});
      end
    end
  end

  function automatic logic [19:0] train(input vec_t v);
`ifdef SNN_REFRACTORY_EN
    return v.exp_r;
`else
    return v.exp_n;
`endif
  endfunction

  task automatic write_w(input vec_t v);
    for (int a = 0; a < 8; a++) begin
      w_we   = 1'b1;
      w_addr = 3'(a);
      w_data = v.w[8*a +: 8];
      @(posedge clk); #1;
    end
    w_we = 1'b0;
  endtask

  task automatic push_train(input vec_t v);
    logic [19:0] tr;
    tr = train(v);
    for (int t = 0; t < 10; t++) exp_q.push_back(tr[2*t +: 2]);
  endtask

  task automatic run_vec(input vec_t v, input bit do_write);
    int cycles;
    if (do_write) write_w(v);
    in_spikes    = v.in_spk;
    sample_ready = 1'b1;
    push_train(v);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({v.name, "_ready_low"}, 32'(ready), 32'd0);
    cycles = 0;
    while (!ready && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
    end
    check({v.name, "_run_cycles"}, cycles, 32'd40);
    repeat (3) @(posedge clk);
    #1;
    check({v.name, "_all_steps"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want test completion");
    $fatal(1);
  end

  initial begin
    int cycles;
    int base;
    vecs[0] = '{"strong",      64'h0000_0000_0000_0046, 4'b0001, 20'h55555, 20'h11111};
    vecs[1] = '{"leak",        64'h0000_1400_0000_0000, 4'b0010, 20'h08080, 20'h20080};
    vecs[2] = '{"neg_sat",     64'h0000_0000_8080_8080, 4'b1111, 20'h00000, 20'h00000};
    vecs[3] = '{"mixed",       64'h0000_1400_0000_0046, 4'b0011, 20'h5D5D5, 20'h31191};
    vecs[4] = '{"no_input",    64'h6464_6464_6464_6464, 4'b0000, 20'h00000, 20'h00000};
    vecs[5] = '{"all_fire",    64'h7F7F_7F7F_0000_0000, 4'b1111, 20'hAAAAA, 20'h22222};
    vecs[6] = '{"after_reset", 64'h0000_0000_0000_0000, 4'b1111, 20'h00000, 20'h00000};

    rst = 1'b0; start = 1'b0; sample_ready = 1'b0; in_spikes = '0;
    w_we = 1'b0; w_addr = '0; w_data = '0;
    #1 rst = 1'b1;
    #1;
    check("rst_ready",      32'(ready),      32'd1);
    check("rst_sample",     32'(sample),     32'd0);
    check("rst_out_valid",  32'(out_valid),  32'd0);
    check("rst_out_spikes", 32'(out_spikes), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int n = 0; n < 6; n++) run_vec(vecs[n], 1'b1);

    // Reset asserted while the fourth timestep is in UPDATE
    write_w(vecs[0]);
    in_spikes = 4'b0001; sample_ready = 1'b1;
    push_train(vecs[0]);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    check("pre_reset_out_spikes", 32'(out_spikes), 32'd1);
    check("pre_reset_ready",      32'(ready),      32'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_ready",      32'(ready),      32'd1);
    check("mid_rst_sample",     32'(sample),     32'd0);
    check("mid_rst_out_spikes", 32'(out_spikes), 32'd0);
    check("mid_rst_out_valid",  32'(out_valid),  32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_vec(vecs[6], 1'b0);
    run_vec(vecs[0], 1'b1);

    // Handshake stall with busy-time start/w_we that must be ignored
    in_spikes = 4'b0001; sample_ready = 1'b0;
    push_train(vecs[0]);
    base  = sample_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      check("stall_sample_low", 32'(sample), 32'd0);
      if (c == 3) begin
        start = 1'b1; w_we = 1'b1; w_addr = 3'd0; w_data = 8'sd0;
      end else begin
        start = 1'b0; w_we = 1'b0;
      end
    end
    check("stall_no_pulse", sample_cnt - base, 32'd0);
    check("stall_busy",     32'(ready),        32'd0);
    sample_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_sample_high", 32'(sample), 32'd1);
    @(posedge clk); #1;
    check("stall_sample_drop", 32'(sample),        32'd0);
    check("stall_one_pulse",   sample_cnt - base, 32'd1);
    cycles = 9;
    while (!ready && cycles < 300) begin
      @(posedge clk); #1;
      cycles++;
    end
    check("stall_run_cycles", cycles, 32'd47);
    repeat (3) @(posedge clk);
    #1;
    check("stall_all_steps",    exp_q.size(),      32'd0);
    check("stall_sample_total", sample_cnt - base, 32'd10);
    exp_q.delete();
    run_vec(vecs[0], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
